// File: rtl/wpreload_pkg.sv
// Shared types and constants for the weight-buffer preload DMA.
package wpreload_pkg;

   localparam int unsigned MAX_BURST_DEF = 16;
   localparam int unsigned BLEN_W        = 9;
   localparam int unsigned COUNT_W       = 17;
   localparam int unsigned DATA_W        = 128;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_DATA  = 3'd2,
      S_DONE  = 3'd3,
      S_REARM = 3'd4
   } state_t;

endpackage

// File: rtl/weight_preload_dma.sv
// Fills the weight buffer from external memory in bounded read bursts.
// Optional XOR checksum of written words: define WPRELOAD_CHECKSUM_EN.
module weight_preload_dma
   import wpreload_pkg::*;
#(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned BUF_ADDR_W = 13,
   parameter int unsigned MAX_BURST  = MAX_BURST_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  preload_req,
   input  logic [ADDR_W-1:0]     preload_base,
   input  logic [COUNT_W-1:0]    preload_count,
   output logic                  preload_done,
   output logic                  preload_err,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic [ADDR_W-1:0]     mem_cmd_addr,
   output logic [BLEN_W-1:0]     mem_cmd_len,
   input  logic                  mem_rd_valid,
   output logic                  mem_rd_ready,
   input  logic [DATA_W-1:0]     mem_rd_data,
   input  logic                  mem_rd_last,
   output logic                  buf_we,
   output logic [BUF_ADDR_W-1:0] buf_waddr,
   output logic [DATA_W-1:0]     buf_wdata,
   output logic [DATA_W-1:0]     preload_csum
);

   localparam int unsigned BUF_DEPTH = 2 ** BUF_ADDR_W;

   state_t                state;
   logic [ADDR_W-1:0]     cur_addr;
   logic [COUNT_W-1:0]    remaining;
   logic [BUF_ADDR_W-1:0] wptr;
   logic [BLEN_W-1:0]     blen;
   logic [BLEN_W-1:0]     beat;
   logic                  clamped;
   logic                  mismatch;

   logic                  over_c;
   logic [COUNT_W-1:0]    eff_c;
   logic                  beat_c;
   logic                  end_cnt_c;
   logic                  mis_c;
   logic [COUNT_W-1:0]    rem_dec_c;
   logic [COUNT_W-1:0]    rem_next_c;
   logic [BLEN_W-1:0]     len_c;
   logic [ADDR_W-1:0]     next_addr_c;

   // Clamp, burst-end detection and the next command's address/length
   always_comb begin
      over_c      = ({1'b0, preload_count} > (COUNT_W+1)'(BUF_DEPTH));
      eff_c       = over_c ? COUNT_W'(BUF_DEPTH) : preload_count;
      beat_c      = mem_rd_valid & mem_rd_ready;
      end_cnt_c   = (beat == (blen - BLEN_W'(1)));
      mis_c       = end_cnt_c ^ mem_rd_last;
      rem_dec_c   = remaining - COUNT_W'(1);
      rem_next_c  = (state == S_IDLE) ? eff_c : rem_dec_c;
      len_c       = (rem_next_c > COUNT_W'(MAX_BURST)) ? BLEN_W'(MAX_BURST)
                                                       : BLEN_W'(rem_next_c);
      next_addr_c = (state == S_IDLE) ? preload_base : (cur_addr + ADDR_W'(blen));
   end

   // Transfer FSM; every output is registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cur_addr      <= '0;
         remaining     <= '0;
         wptr          <= '0;
         blen          <= '0;
         beat          <= '0;
         clamped       <= 1'b0;
         mismatch      <= 1'b0;
         preload_done  <= 1'b0;
         preload_err   <= 1'b0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_addr  <= '0;
         mem_cmd_len   <= '0;
         mem_rd_ready  <= 1'b0;
         buf_we        <= 1'b0;
         buf_waddr     <= '0;
         buf_wdata     <= '0;
      end else begin
         buf_we       <= 1'b0;
         preload_done <= 1'b0;
         preload_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (preload_req) begin
                  cur_addr  <= preload_base;
                  remaining <= eff_c;
                  clamped   <= over_c;
                  mismatch  <= 1'b0;
                  wptr      <= '0;
                  if (eff_c == '0) begin
                     state <= S_DONE;
                  end else begin
                     state         <= S_CMD;
                     mem_cmd_valid <= 1'b1;
                     mem_cmd_addr  <= next_addr_c;
                     mem_cmd_len   <= len_c;
                  end
               end
            end
            S_CMD: begin
               if (mem_cmd_ready) begin
                  mem_cmd_valid <= 1'b0;
                  blen          <= mem_cmd_len;
                  beat          <= '0;
                  mem_rd_ready  <= 1'b1;
                  state         <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_c) begin
                  buf_we    <= 1'b1;
                  buf_waddr <= wptr;
                  buf_wdata <= mem_rd_data;
                  wptr      <= wptr + BUF_ADDR_W'(1);
                  beat      <= beat + BLEN_W'(1);
                  remaining <= rem_dec_c;
                  // Counted end and memory's last flag must agree, else abort
                  if (mis_c) begin
                     mismatch     <= 1'b1;
                     mem_rd_ready <= 1'b0;
                     state        <= S_DONE;
                  end else if (end_cnt_c) begin
                     cur_addr     <= next_addr_c;
                     mem_rd_ready <= 1'b0;
                     if (rem_dec_c != '0) begin
                        state         <= S_CMD;
                        mem_cmd_valid <= 1'b1;
                        mem_cmd_addr  <= next_addr_c;
                        mem_cmd_len   <= len_c;
                     end else begin
                        state <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               preload_done <= 1'b1;
               preload_err  <= clamped | mismatch;
               state        <= S_REARM;
            end
            S_REARM: begin
               // A level-held request must drop before another accept
               if (!preload_req) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef WPRELOAD_CHECKSUM_EN
   logic [DATA_W-1:0] csum_acc;

   // Fold each written word; publish alongside preload_done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_acc     <= '0;
         preload_csum <= '0;
      end else begin
         if ((state == S_IDLE) && preload_req) begin
            csum_acc <= '0;
         end else if ((state == S_DATA) && beat_c) begin
            csum_acc <= csum_acc ^ mem_rd_data;
         end
         if (state == S_DONE) begin
            preload_csum <= csum_acc;
         end
      end
   end
`else
   assign preload_csum = '0;
`endif

endmodule

// File: tb/tb_weight_preload_dma.sv
// Directed bench for weight_preload_dma with a bursting memory responder.
module tb_weight_preload_dma;
   import wpreload_pkg::*;

   localparam int unsigned AW    = 16;
   localparam int unsigned BAW   = 13;
   localparam int unsigned DEPTH = 8192;

   logic             clk;
   logic             rst_n;
   logic             preload_req;
   logic [AW-1:0]    preload_base;
   logic [16:0]      preload_count;
   logic             preload_done;
   logic             preload_err;
   logic             mem_cmd_valid;
   logic             mem_cmd_ready;
   logic [AW-1:0]    mem_cmd_addr;
   logic [8:0]       mem_cmd_len;
   logic             mem_rd_valid;
   logic             mem_rd_ready;
   logic [127:0]     mem_rd_data;
   logic             mem_rd_last;
   logic             buf_we;
   logic [BAW-1:0]   buf_waddr;
   logic [127:0]     buf_wdata;
   logic [127:0]     preload_csum;

   weight_preload_dma #(.ADDR_W(AW), .BUF_ADDR_W(BAW), .MAX_BURST(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .preload_req(preload_req), .preload_base(preload_base), .preload_count(preload_count),
      .preload_done(preload_done), .preload_err(preload_err),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
      .mem_rd_data(mem_rd_data), .mem_rd_last(mem_rd_last),
      .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
      .preload_csum(preload_csum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // stimulus-side controls (written by the main sequence only)
   logic [AW-1:0] cur_base;
   int            req_seq;
   int            req_cyc;
   bit            cmd_stall;
   bit            rd_stall;
   int            early_last;
   int            w0, c0, d0, e0, l0;
   bit            done_seen;

   // monitor / memory-model state (written by the negedge process only)
   int            cyc = 0;
   int            seen_seq = 0;
   int            wr_idx = 0;
   int            wr_cnt = 0;
   int            wr_err = 0;
   int            we_lat_err = 0;
   int            stray_err = 0;
   int            cmd_cnt = 0;
   int            done_cnt = 0;
   int            first_cmd_cyc = -1;
   int            last_we_cyc = 0;
   int            last_done_cyc = 0;
   logic          last_err = 1'b0;
   logic [127:0]  last_csum = '0;
   logic [AW-1:0] cmd_addr_q[$];
   logic [8:0]    cmd_len_q[$];
   bit            busy = 1'b0;
   bit            beat_pend = 1'b0;
   logic [AW-1:0] m_addr = '0;
   int            m_left = 0;
   int            m_beat = 0;

   function automatic logic [127:0] mdata(input logic [AW-1:0] a);
      return {16'hA5C3, a, ~a, a ^ 16'h1234, a * 16'd7, 32'h0F0F_0000 | 32'(a), a + 16'd1};
   endfunction

   function automatic logic [127:0] exp_csum(input logic [AW-1:0] base, input int n);
      logic [127:0] x;
      x = '0;
      for (int i = 0; i < n; i++) x ^= mdata(base + 16'(i));
`ifdef WPRELOAD_CHECKSUM_EN
      return x;
`else
      return (x & '0);
`endif
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor outputs, then drive the memory side for the coming posedge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (seen_seq != req_seq) begin
         seen_seq      = req_seq;
         wr_idx        = 0;
         first_cmd_cyc = -1;
      end
      if (rst_n) begin
         if (buf_we != beat_pend) we_lat_err++;
         if (buf_we) begin
            if (buf_waddr != BAW'(wr_idx) || buf_wdata != mdata(cur_base + 16'(wr_idx))) wr_err++;
            wr_idx++;
            wr_cnt++;
            last_we_cyc = cyc;
         end
         if (mem_cmd_valid && first_cmd_cyc < 0) first_cmd_cyc = cyc;
         if (preload_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_err      = preload_err;
            last_csum     = preload_csum;
         end
         if (preload_err && !preload_done) stray_err++;
      end
      if (!rst_n) begin
         busy          = 1'b0;
         beat_pend     = 1'b0;
         mem_cmd_ready = 1'b0;
         mem_rd_valid  = 1'b0;
         mem_rd_data   = '0;
         mem_rd_last   = 1'b0;
      end else begin
         mem_cmd_ready = !cmd_stall || ($urandom_range(0, 1) == 1);
         mem_rd_valid  = busy && (!rd_stall || ($urandom_range(0, 2) != 0));
         mem_rd_data   = busy ? mdata(m_addr) : '0;
         mem_rd_last   = busy && ((m_left == 1) || (m_beat == early_last));
         if (mem_cmd_valid && mem_cmd_ready) begin
            cmd_addr_q.push_back(mem_cmd_addr);
            cmd_len_q.push_back(mem_cmd_len);
            cmd_cnt++;
            m_addr = mem_cmd_addr;
            m_left = int'(mem_cmd_len);
            m_beat = 0;
            busy   = 1'b1;
         end
         beat_pend = mem_rd_valid && mem_rd_ready;
         if (beat_pend) begin
            if (mem_rd_last) busy = 1'b0;
            m_addr = m_addr + 16'd1;
            m_left--;
            m_beat++;
         end
      end
   end

   task automatic run_req(input string tag, input logic [AW-1:0] base, input logic [16:0] count,
                          input int budget);
      @(negedge clk);
      #1;
      cur_base      = base;
      req_seq++;
      preload_base  = base;
      preload_count = count;
      preload_req   = 1'b1;
      req_cyc       = cyc;
      w0 = wr_cnt; c0 = cmd_cnt; d0 = done_cnt; e0 = wr_err; l0 = we_lat_err;
      done_seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt != d0) begin
            done_seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 128'(done_seen), 128'(1));
   endtask

   task automatic drop_req();
      @(negedge clk);
      #1;
      preload_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_xfer(input string tag, input int n_wr, input int n_cmd, input logic err,
                             input logic [AW-1:0] base);
      check({tag, "_writes"}, 128'(wr_cnt - w0), 128'(n_wr));
      check({tag, "_wdata"}, 128'(wr_err - e0), 128'(0));
      check({tag, "_we_lat"}, 128'(we_lat_err - l0), 128'(0));
      check({tag, "_cmds"}, 128'(cmd_cnt - c0), 128'(n_cmd));
      check({tag, "_done_cnt"}, 128'(done_cnt - d0), 128'(1));
      check({tag, "_err"}, 128'(last_err), 128'(err));
      check({tag, "_csum"}, last_csum, exp_csum(base, n_wr));
   endtask

   initial begin
      rst_n = 1'b0; preload_req = 1'b0; preload_base = '0; preload_count = '0;
      cur_base = '0; req_seq = 0; req_cyc = 0; cmd_stall = 1'b0; rd_stall = 1'b0;
      early_last = -1; w0 = 0; c0 = 0; d0 = 0; e0 = 0; l0 = 0; done_seen = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check("rst_ctrl", 128'({preload_done, preload_err, mem_cmd_valid, mem_rd_ready, buf_we}), 128'(0));
      check("rst_cmd", 128'({mem_cmd_addr, mem_cmd_len}), 128'(0));
      check("rst_waddr", 128'(buf_waddr), 128'(0));
      check("rst_wdata", buf_wdata, 128'(0));
      check("rst_csum", preload_csum, 128'(0));
      rst_n = 1'b1;

      // three bursts: 16 + 16 + 8
      run_req("t1", 16'h0100, 17'd40, 500);
      check_xfer("t1", 40, 3, 1'b0, 16'h0100);
      check("t1_cmd0", 128'({cmd_addr_q[c0], cmd_len_q[c0]}), 128'({16'h0100, 9'd16}));
      check("t1_cmd1", 128'({cmd_addr_q[c0+1], cmd_len_q[c0+1]}), 128'({16'h0110, 9'd16}));
      check("t1_cmd2", 128'({cmd_addr_q[c0+2], cmd_len_q[c0+2]}), 128'({16'h0120, 9'd8}));
      check("t1_cmd_lat", 128'(first_cmd_cyc - req_cyc), 128'(1));
      check("t1_done_after_we", 128'(last_done_cyc - last_we_cyc), 128'(1));
      drop_req();

      // zero-length request
      run_req("t2", 16'h0055, 17'd0, 50);
      check_xfer("t2", 0, 0, 1'b0, 16'h0055);
      check("t2_done_lat", 128'(last_done_cyc - req_cyc), 128'(2));
      drop_req();

      // clamped request with address wrap past 0xFFFF
      run_req("t3", 16'hFFF0, 17'(DEPTH + 5), 20000);
      check_xfer("t3", DEPTH, 512, 1'b1, 16'hFFF0);
      check("t3_last_cmd", 128'({cmd_addr_q[c0+511], cmd_len_q[c0+511]}), 128'({16'h1FE0, 9'd16}));
      drop_req();

      // early last on beat 5, then hold the request high
      early_last = 5;
      run_req("t4", 16'h0200, 17'd16, 200);
      check_xfer("t4", 6, 1, 1'b1, 16'h0200);
      repeat (10) @(negedge clk);
      #1;
      check("t4_hold_no_redone", 128'(done_cnt - d0), 128'(1));
      check("t4_hold_no_cmd", 128'(cmd_cnt - c0), 128'(1));
      early_last = -1;
      drop_req();

      // re-raise: new transfer restarts at buffer address 0
      run_req("t5", 16'h0040, 17'd3, 100);
      check_xfer("t5", 3, 1, 1'b0, 16'h0040);
      check("t5_cmd", 128'({cmd_addr_q[c0], cmd_len_q[c0]}), 128'({16'h0040, 9'd3}));
      drop_req();

      // stalls plus an asynchronous reset mid-burst
      cmd_stall = 1'b1;
      rd_stall  = 1'b1;
      @(negedge clk);
      #1;
      cur_base = 16'h0800; req_seq++; preload_base = 16'h0800; preload_count = 17'd40;
      preload_req = 1'b1; w0 = wr_cnt;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (wr_cnt - w0 >= 10) break;
      end
      check("t6_progress", 128'(wr_cnt - w0 >= 10), 128'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      preload_req = 1'b0;
      #1;
      check("t6_rst_ctrl", 128'({preload_done, preload_err, mem_cmd_valid, mem_rd_ready, buf_we}), 128'(0));
      check("t6_rst_addr", 128'({mem_cmd_addr, mem_cmd_len, buf_waddr}), 128'(0));
      check("t6_rst_wdata", buf_wdata, 128'(0));
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      run_req("t6", 16'h3000, 17'd37, 2000);
      check_xfer("t6", 37, 3, 1'b0, 16'h3000);
      check("t6_cmd2", 128'({cmd_addr_q[c0+2], cmd_len_q[c0+2]}), 128'({16'h3020, 9'd5}));
      drop_req();

      check("stray_err", 128'(stray_err), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
